// File: rtl/md_pair_force_engine_if.sv
// Stream bundle for the pair force engine: position load stream in, force drain stream out.
// The host side uses the master modport and the engine uses the slave modport.
interface md_pair_force_engine_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
);
    logic              pos_valid;
    logic              pos_ready;
    logic [DATA_W-1:0] pos_data;
    logic              force_valid;
    logic              force_ready;
    logic [DATA_W-1:0] force_data;
    logic [IDX_W-1:0]  force_idx;

    modport master (
        output pos_valid, pos_data, force_ready,
        input  pos_ready, force_valid, force_data, force_idx
    );

    modport slave (
        input  pos_valid, pos_data, force_ready,
        output pos_ready, force_valid, force_data, force_idx
    );
endinterface

// File: rtl/md_pair_force_engine.sv
// Pairwise cutoff-limited linear-spring force engine: loads N positions, accumulates
// one pair term per cycle for each particle, and streams the saturated forces out.
module md_pair_force_engine #(
    parameter int                       N         = 16,
    parameter int                       DATA_W    = 32,
    parameter int                       FRAC_BITS = 16,
    parameter logic signed [DATA_W-1:0] SPRING_K  = 32'h0001_0000,
    parameter logic [DATA_W-1:0]        CUTOFF    = 32'h0004_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag,
    md_pair_force_engine_if.slave    bus
);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W  = DATA_W + IDX_W + 1;
    localparam int PROD_W = 2 * DATA_W + 1;
    localparam logic [IDX_W-1:0]         LAST  = IDX_W'(N - 1);
    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUT, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0]        mem [N];
    logic signed [DATA_W-1:0] pos_i_reg, pos_j_reg;
    logic                     mem_we;

    logic [IDX_W-1:0]         k_reg, k_next;
    logic [IDX_W-1:0]         i_reg, i_next;
    logic [IDX_W-1:0]         j_reg, j_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic [DATA_W-1:0]        force_data_reg, force_data_next;
    logic [IDX_W-1:0]         force_idx_reg, force_idx_next;
    logic                     sat_reg, sat_next;

    logic signed [DATA_W:0]   diff;
    logic [DATA_W:0]          diff_abs;
    logic signed [PROD_W-1:0] prod, prod_sh;
    logic                     in_range, term_ovf, term_sat;
    logic signed [DATA_W-1:0] term;
    logic signed [ACC_W-1:0]  sum;
    logic                     sum_sat;
    logic signed [DATA_W-1:0] sum_clip;

    // Pair term datapath: operands come from the registered memory reads of mem[i], mem[j].
    always_comb begin
        diff     = {pos_j_reg[DATA_W-1], pos_j_reg} - {pos_i_reg[DATA_W-1], pos_i_reg};
        diff_abs = diff[DATA_W] ? (~diff + 1'b1) : diff;
        prod     = PROD_W'(diff) * PROD_W'(SPRING_K);
        prod_sh  = prod >>> FRAC_BITS;
        in_range = (j_reg != i_reg) && (diff_abs < {1'b0, CUTOFF});
        term_ovf = !((&prod_sh[PROD_W-1:DATA_W-1]) || !(|prod_sh[PROD_W-1:DATA_W-1]));
        term     = '0;
        term_sat = 1'b0;
        if (in_range) begin
            if (term_ovf) begin
                term_sat = 1'b1;
                term     = prod_sh[PROD_W-1] ? S_MIN : S_MAX;
            end else begin
                term = prod_sh[DATA_W-1:0];
            end
        end
        sum      = acc_reg + ACC_W'(term);
        sum_sat  = !((&sum[ACC_W-1:DATA_W-1]) || !(|sum[ACC_W-1:DATA_W-1]));
        sum_clip = sum_sat ? (sum[ACC_W-1] ? S_MIN : S_MAX) : sum[DATA_W-1:0];
    end

    always_comb begin
        state_next      = state_reg;
        k_next          = k_reg;
        i_next          = i_reg;
        j_next          = j_reg;
        acc_next        = acc_reg;
        force_data_next = force_data_reg;
        force_idx_next  = force_idx_reg;
        sat_next        = sat_reg;
        mem_we          = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        bus.pos_ready   = 1'b0;
        bus.force_valid = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    sat_next   = 1'b0;
                    k_next     = '0;
                    i_next     = '0;
                    j_next     = '0;
                end
            end
            S_LOAD: begin
                busy          = 1'b1;
                bus.pos_ready = 1'b1;
                if (bus.pos_valid) begin
                    mem_we = 1'b1;
                    k_next = k_reg + 1'b1;
                    if (k_reg == LAST) begin
                        state_next = S_COMPUTE;
                        i_next     = '0;
                        j_next     = '0;
                        acc_next   = '0;
                    end
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (term_sat)
                    sat_next = 1'b1;
                if (j_reg == LAST) begin
                    force_data_next = sum_clip;
                    force_idx_next  = i_reg;
                    if (sum_sat)
                        sat_next = 1'b1;
                    state_next = S_OUT;
                end else begin
                    acc_next = sum;
                    j_next   = j_reg + 1'b1;
                end
            end
            S_OUT: begin
                busy            = 1'b1;
                bus.force_valid = 1'b1;
                if (bus.force_ready) begin
                    if (i_reg == LAST) begin
                        state_next = S_DONE;
                    end else begin
                        i_next     = i_reg + 1'b1;
                        j_next     = '0;
                        acc_next   = '0;
                        state_next = S_COMPUTE;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            k_reg          <= '0;
            i_reg          <= '0;
            j_reg          <= '0;
            acc_reg        <= '0;
            force_data_reg <= '0;
            force_idx_reg  <= '0;
            sat_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            k_reg          <= k_next;
            i_reg          <= i_next;
            j_reg          <= j_next;
            acc_reg        <= acc_next;
            force_data_reg <= force_data_next;
            force_idx_reg  <= force_idx_next;
            sat_reg        <= sat_next;
        end
    end

    // Reads are addressed by the next i/j so the registered data lines up with i_reg/j_reg.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[k_reg] <= bus.pos_data;
        pos_i_reg <= mem[i_next];
        pos_j_reg <= mem[j_next];
    end

    assign bus.force_data = force_data_reg;
    assign bus.force_idx  = force_idx_reg;
    assign sat_flag       = sat_reg;
endmodule

// File: tb/tb_md_pair_force_engine.sv
// Randomised and directed bench for md_pair_force_engine with an arithmetic force model
// and a per-cycle compare process on the force stream.
module tb_md_pair_force_engine;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam logic signed [31:0] K_DEF = 32'h0001_0000;
    localparam logic signed [31:0] K_SAT = 32'h7FFF_0000;
    localparam longint CUTOFF_L = 64'sh4_0000;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    logic pos_valid = 1'b0;
    logic force_ready = 1'b1;
    logic [31:0] pos_data = '0;
    logic start_a, start_b, busy_a, busy_b, done_a, done_b, sat_a, sat_b;
    logic m_busy, m_done, m_sat, m_pos_ready, m_force_valid;
    logic [31:0] m_force_data;
    logic [IW-1:0] m_force_idx;

    md_pair_force_engine_if #(.DATA_W(DW), .IDX_W(IW)) bus_a ();
    md_pair_force_engine_if #(.DATA_W(DW), .IDX_W(IW)) bus_b ();

    assign start_a           = start & ~sel;
    assign start_b           = start & sel;
    assign bus_a.pos_valid   = pos_valid;
    assign bus_a.pos_data    = pos_data;
    assign bus_a.force_ready = force_ready;
    assign bus_b.pos_valid   = pos_valid;
    assign bus_b.pos_data    = pos_data;
    assign bus_b.force_ready = force_ready;

    md_pair_force_engine #(.N(N), .DATA_W(DW), .FRAC_BITS(16), .SPRING_K(K_DEF),
                           .CUTOFF(32'h0004_0000)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .sat_flag(sat_a), .bus(bus_a));

    md_pair_force_engine #(.N(N), .DATA_W(DW), .FRAC_BITS(16), .SPRING_K(K_SAT),
                           .CUTOFF(32'h0004_0000)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .sat_flag(sat_b), .bus(bus_b));

    assign m_busy        = sel ? busy_b : busy_a;
    assign m_done        = sel ? done_b : done_a;
    assign m_sat         = sel ? sat_b : sat_a;
    assign m_pos_ready   = sel ? bus_b.pos_ready : bus_a.pos_ready;
    assign m_force_valid = sel ? bus_b.force_valid : bus_a.force_valid;
    assign m_force_data  = sel ? bus_b.force_data : bus_a.force_data;
    assign m_force_idx   = sel ? bus_b.force_idx : bus_a.force_idx;

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_total = 0, hs_base = 0, stall_total = 0, load_total = 0, done_total = 0, done_cyc = 0;
    bit exp_active = 1'b0;
    int ready_mode = 0;
    logic [31:0] pos_arr [N];
    logic [31:0] exp_force [N];
    logic [31:0] got_force [N];
    bit exp_sat;
    int last_dur, last_stalls, last_load;
    logic [31:0] dir_pos [N] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h000A_0000};
    logic [31:0] dir_exp [N] = '{32'h0003_0000, 32'h0000_0000, 32'hFFFD_0000, 32'h0000_0000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Forces straight from the pair-sum definition, in 64-bit integer arithmetic.
    task automatic run_model(input logic signed [31:0] k);
        longint acc, d, ad, t, kl;
        kl = longint'(k);
        exp_sat = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = 0; j < N; j++) begin
                if (j == i) continue;
                d  = longint'($signed(pos_arr[j])) - longint'($signed(pos_arr[i]));
                ad = (d < 0) ? -d : d;
                if (ad >= CUTOFF_L) continue;
                t = (d * kl) >>> 16;
                if (t > SMAX) begin t = SMAX; exp_sat = 1'b1; end
                else if (t < SMIN) begin t = SMIN; exp_sat = 1'b1; end
                acc += t;
            end
            if (acc > SMAX) begin acc = SMAX; exp_sat = 1'b1; end
            else if (acc < SMIN) begin acc = SMIN; exp_sat = 1'b1; end
            exp_force[i] = 32'(acc);
        end
    endtask

    task automatic compare_loop();
        bit prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic [IW-1:0] prev_idx = '0;
        int e;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_valid", 32'(m_force_valid), 32'd1);
                check("hold_data", m_force_data, prev_data);
                check("hold_idx", 32'(m_force_idx), 32'(prev_idx));
            end
            if (!exp_active) begin
                check("idle_force_valid", 32'(m_force_valid), 32'd0);
            end else if (m_force_valid && force_ready) begin
                e = hs_total - hs_base;
                if (e < N) begin
                    check("force_data", m_force_data, exp_force[e]);
                    check("force_idx", 32'(m_force_idx), 32'(e));
                    got_force[e] = m_force_data;
                end else begin
                    check("extra_handshake", 32'(e), 32'(N - 1));
                end
            end
            if (m_force_valid && force_ready) hs_total++;
            if (m_force_valid && !force_ready) stall_total++;
            if (m_pos_ready) load_total++;
            if (m_done) begin done_total++; done_cyc = cyc; end
            prev_stall = m_force_valid && !force_ready;
            prev_data  = m_force_data;
            prev_idx   = m_force_idx;
        end
    endtask

    task automatic ready_driver();
        int hold = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: force_ready = 1'b1;
                1: force_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (m_force_valid && m_force_idx == 2 && hold < 5) begin
                        force_ready = 1'b0;
                        hold++;
                    end else force_ready = 1'b1;
                end
            endcase
        end
    endtask

    // gap_mode: 0 none, 1 alternate starting with a gap, 2 random.
    task automatic run_block(input bit sel_dut, input int gap_mode, input int rmode,
                             input bit glitch, input bit abort);
        int t, gaps, stall_base, load_base, done_base, start_cyc, exp_dur;
        t = 0;
        while ((busy_a || busy_b || done_a || done_b) && t < 100) begin @(posedge clk); t++; end
        @(posedge clk); #1;
        sel = sel_dut;
        ready_mode = rmode;
        run_model(sel_dut ? K_SAT : K_DEF);
        for (int i = 0; i < N; i++) got_force[i] = 32'hDEAD_BEEF;
        hs_base = hs_total; stall_base = stall_total; load_base = load_total; done_base = done_total;
        gaps = 0;
        start = 1'b1; start_cyc = cyc; exp_active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("sat_clear_on_start", 32'(m_sat), 32'd0);
        check("busy_in_load", 32'(m_busy), 32'd1);
        check("pos_ready_in_load", 32'(m_pos_ready), 32'd1);
        for (int k = 0; k < N; k++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                pos_valid = 1'b0; pos_data = $urandom;
                @(posedge clk); #1;
                gaps++;
            end
            pos_valid = 1'b1; pos_data = pos_arr[k];
            @(posedge clk); #1;
        end
        pos_valid = 1'b0; pos_data = $urandom;
        if (glitch) begin
            start = 1'b1; @(posedge clk); #1; start = 1'b0;
        end
        if (abort) begin
            repeat (2) @(posedge clk);
            #1; reset = 1'b1; exp_active = 1'b0;
            @(posedge clk); #1; reset = 1'b0;
            check("abort_busy", 32'(m_busy), 32'd0);
            check("abort_force_valid", 32'(m_force_valid), 32'd0);
            repeat (40) @(posedge clk);
            check("no_stale_done", 32'(done_total - done_base), 32'd0);
            return;
        end
        t = 0;
        while (done_total == done_base && t < 3000) begin @(posedge clk); t++; end
        if (done_total == done_base) begin
            check("done_timeout", 32'(done_total - done_base), 32'd1);
            exp_active = 1'b0;
            return;
        end
        last_stalls = stall_total - stall_base;
        last_load   = load_total - load_base;
        last_dur    = done_cyc - start_cyc + 1;
        exp_dur     = 1 + N + gaps + N * (N + 1) + last_stalls + 1;
        check("run_cycles", 32'(last_dur), 32'(exp_dur));
        check("load_cycles", 32'(last_load), 32'(N + gaps));
        check("handshakes", 32'(hs_total - hs_base), 32'(N));
        check("sat_flag", 32'(m_sat), 32'(exp_sat));
        repeat (3) @(posedge clk);
        check("done_once", 32'(done_total - done_base), 32'd1);
        exp_active = 1'b0;
        #1;
    endtask

    task automatic check_dir(input string tag);
        for (int i = 0; i < N; i++) check(tag, got_force[i], dir_exp[i]);
    endtask

    initial begin
        logic [31:0] base;
        repeat (2) begin
            @(posedge clk); #1;
            start = 1'($urandom); pos_valid = 1'($urandom); pos_data = $urandom;
        end
        @(negedge clk);
        check("rst_busy_a", 32'(busy_a), 0);        check("rst_busy_b", 32'(busy_b), 0);
        check("rst_done_a", 32'(done_a), 0);        check("rst_done_b", 32'(done_b), 0);
        check("rst_sat_a", 32'(sat_a), 0);          check("rst_sat_b", 32'(sat_b), 0);
        check("rst_pos_ready_a", 32'(bus_a.pos_ready), 0);
        check("rst_pos_ready_b", 32'(bus_b.pos_ready), 0);
        check("rst_force_valid_a", 32'(bus_a.force_valid), 0);
        check("rst_force_valid_b", 32'(bus_b.force_valid), 0);
        check("rst_force_data_a", bus_a.force_data, 0);
        check("rst_force_data_b", bus_b.force_data, 0);
        check("rst_force_idx_a", 32'(bus_a.force_idx), 0);
        check("rst_force_idx_b", 32'(bus_b.force_idx), 0);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; pos_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy_a | busy_b), 0);
        fork
            compare_loop();
            ready_driver();
        join_none

        for (int i = 0; i < N; i++) pos_arr[i] = dir_pos[i];
        run_block(1'b0, 0, 0, 1'b0, 1'b0);
        check_dir("dir_force");
        check("dir_latency", 32'(last_dur), 32'd26);

        run_block(1'b0, 0, 2, 1'b0, 1'b0);
        check_dir("bp_force");
        check("bp_stalls", 32'(last_stalls), 32'd5);

        run_block(1'b0, 1, 0, 1'b0, 1'b0);
        check_dir("gap_force");
        check("gap_load_cycles", 32'(last_load), 32'd8);

        run_block(1'b0, 0, 0, 1'b1, 1'b0);
        check_dir("glitch_force");
        check("glitch_latency", 32'(last_dur), 32'd26);

        pos_arr = '{32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        run_block(1'b1, 0, 0, 1'b0, 1'b0);
        check("sat_idx0", got_force[0], 32'h7FFF_FFFF);
        repeat (5) @(posedge clk);
        #1 check("sat_sticky", 32'(sat_b), 32'd1);
        pos_arr = '{32'h0, 32'h0, 32'h0, 32'h0};
        run_block(1'b1, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) pos_arr[i] = dir_pos[i];
        run_block(1'b0, 0, 0, 1'b0, 1'b1);
        run_block(1'b0, 0, 0, 1'b0, 1'b0);
        check_dir("post_abort_force");

        for (int r = 0; r < 25; r++) begin
            base = $urandom;
            for (int k = 0; k < N; k++) begin
                if (r % 5 == 4)      pos_arr[k] = $urandom;
                else if (r % 5 == 3) pos_arr[k] = base + ($urandom_range(0, 3) << 18);
                else                 pos_arr[k] = base + $urandom_range(0, 32'h000C_0000) - 32'h0006_0000;
            end
            run_block(1'($urandom_range(0, 1)), 2, 1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
